// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler that merges N_CH show-ahead sample FIFOs into one
// registered valid/ready stream, with optional forced idle spacing between issues.
module fifo_rr_scheduler #(
    parameter int N_CH    = 2,
    parameter int D_WIDTH = 24,
    parameter int GAP     = 0,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_CH*D_WIDTH-1:0] data_i,
    input  logic [N_CH-1:0]         empty_i,
    output logic [N_CH-1:0]         rdreq_o,
    output logic [D_WIDTH-1:0]      data_o,
    output logic [CH_W-1:0]         ch_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    idle_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAPW
    } state_t;

    localparam logic [7:0] GAP_M1 = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t          state_q, state_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic [CH_W-1:0] last_q;
    logic [CH_W-1:0] grant;
    logic            any_req;
    logic            slot_free;
    logic            issue;

    // Scan last+1 .. last+N_CH; iterating downward lets the nearest requester win.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = N_CH; i >= 1; i--) begin
            if (!empty_i[(int'(last_q) + i) % N_CH]) begin
                grant   = CH_W'((int'(last_q) + i) % N_CH);
                any_req = 1'b1;
            end
        end
    end

    assign slot_free = (state_q == S_IDLE) ||
                       ((state_q == S_HOLD) && ready_i && (GAP == 0));
    assign issue     = slot_free && any_req && !rst_i;

    always_comb begin
        rdreq_o = '0;
        if (issue) begin
            rdreq_o[grant] = 1'b1;
        end
    end

    // A GAP of 1 returns straight to IDLE; longer gaps spend GAP-1 cycles in GAPW.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ready_i) begin
                    if (GAP == 0) begin
                        state_d = issue ? S_HOLD : S_IDLE;
                    end else begin
                        gap_cnt_d = GAP_M1;
                        state_d   = (GAP_M1 == 8'd0) ? S_IDLE : S_GAPW;
                    end
                end
            end
            S_GAPW: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= 8'd0;
            last_q    <= CH_W'(N_CH - 1);
            data_o    <= '0;
            ch_o      <= '0;
            valid_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            valid_o   <= (state_d == S_HOLD);
            if (issue) begin
                data_o <= data_i[int'(grant)*D_WIDTH +: D_WIDTH];
                ch_o   <= grant;
                last_q <= grant;
            end
        end
    end

    assign idle_o = (state_q == S_IDLE) && (&empty_i);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: three instances cover the 2-channel,
// 4-channel and GAP=3 configurations with hand-scripted FIFO heads.
module tb_fifo_rr_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [47:0] data2;
    logic [1:0]  empty2, rdreq2;
    logic [23:0] dout2;
    logic        ch2, valid2, ready2, idle2;

    logic [95:0] data4;
    logic [3:0]  empty4, rdreq4;
    logic [23:0] dout4;
    logic [1:0]  ch4;
    logic        valid4, ready4, idle4;

    logic [47:0] datag;
    logic [1:0]  emptyg, rdreqg;
    logic [23:0] doutg;
    logic        chg, validg, readyg, idleg;

    int checks = 0;
    int errors = 0;

    fifo_rr_scheduler #(.N_CH(2), .D_WIDTH(24), .GAP(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(data2), .empty_i(empty2), .rdreq_o(rdreq2),
        .data_o(dout2), .ch_o(ch2), .valid_o(valid2), .ready_i(ready2), .idle_o(idle2)
    );

    fifo_rr_scheduler #(.N_CH(4), .D_WIDTH(24), .GAP(0)) dut4 (
        .clk_i(clk), .rst_i(rst), .data_i(data4), .empty_i(empty4), .rdreq_o(rdreq4),
        .data_o(dout4), .ch_o(ch4), .valid_o(valid4), .ready_i(ready4), .idle_o(idle4)
    );

    fifo_rr_scheduler #(.N_CH(2), .D_WIDTH(24), .GAP(3)) dutg (
        .clk_i(clk), .rst_i(rst), .data_i(datag), .empty_i(emptyg), .rdreq_o(rdreqg),
        .data_o(doutg), .ch_o(chg), .valid_o(validg), .ready_i(readyg), .idle_o(idleg)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        empty2 = 2'b00;
        data2  = {24'hA00001, 24'h000001};
        ready2 = 1'b1;
        empty4 = 4'hF;
        data4  = '0;
        ready4 = 1'b1;
        emptyg = 2'b11;
        datag  = '0;
        readyg = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (rdreq2 !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_rdreq: got %b expected 00", rdreq2);
        end
        checks++;
        if (valid2 !== 1'b0 || dout2 !== 24'h0 || ch2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h ch=%0d expected 0/0/0",
                     valid2, dout2, ch2);
        end
        checks++;
        if (valid4 !== 1'b0 || validg !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid_others: got %b %b expected 0 0", valid4, validg);
        end
        empty2 = 2'b11;
        #1;
        checks++;
        if (idle2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b expected 1", idle2);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [1:0]  e_in  [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11};
        logic [23:0] d0_in [6] = '{24'h000001, 24'h000002, 24'h000002, 24'h000002, 24'h000002, 24'h000002};
        logic [23:0] d1_in [6] = '{24'hA00001, 24'hA00001, 24'hA00002, 24'hA00002, 24'hA00002, 24'hA00002};
        logic [1:0]  x_rd  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        logic        x_v   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        x_ch  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [23:0] x_d   [6] = '{24'h0, 24'h000001, 24'hA00001, 24'h000002, 24'hA00002, 24'h0};
        ready2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            empty2 = e_in[i];
            data2  = {d1_in[i], d0_in[i]};
            @(negedge clk);
            checks++;
            if (rdreq2 !== x_rd[i] || valid2 !== x_v[i]) begin
                errors++;
                $display("[TB] FAIL rr_step%0d: got rdreq=%b valid=%b expected %b %b",
                         i, rdreq2, valid2, x_rd[i], x_v[i]);
            end
            if (x_v[i]) begin
                checks++;
                if (dout2 !== x_d[i] || ch2 !== x_ch[i]) begin
                    errors++;
                    $display("[TB] FAIL rr_data%0d: got ch=%0d data=%h expected ch=%0d data=%h",
                             i, ch2, dout2, x_ch[i], x_d[i]);
                end
            end
            if (i == 5) begin
                checks++;
                if (idle2 !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rr_idle: got %b expected 1", idle2);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        empty2 = 2'b10;
        data2  = {24'h0, 24'h123456};
        ready2 = 1'b0;
        @(negedge clk);
        checks++;
        if (rdreq2 !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_first_grant: got %b expected 01", rdreq2);
        end
        tick();
        data2 = {24'h0, 24'h654321};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (valid2 !== 1'b1 || dout2 !== 24'h123456 || rdreq2 !== 2'b00) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h rdreq=%b expected 1 123456 00",
                         i, valid2, dout2, rdreq2);
            end
            tick();
        end
        ready2 = 1'b1;
        @(negedge clk);
        checks++;
        if (rdreq2 !== 2'b01 || dout2 !== 24'h123456) begin
            errors++;
            $display("[TB] FAIL bp_release: got rdreq=%b data=%h expected 01 123456", rdreq2, dout2);
        end
        tick();
        empty2 = 2'b11;
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b1 || dout2 !== 24'h654321 || ch2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_next: got valid=%b data=%h ch=%0d expected 1 654321 0",
                     valid2, dout2, ch2);
        end
        tick();
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got valid=%b expected 0", valid2);
        end
        tick();
    endtask

    task automatic test_skip_empty;
        logic [3:0]  e_in [5] = '{4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
        logic [23:0] d_in [5] = '{24'h000C01, 24'h000C02, 24'h000C03, 24'h000C03, 24'h000C03};
        logic [3:0]  x_rd [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic        x_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [23:0] x_d  [5] = '{24'h0, 24'h000C01, 24'h000C02, 24'h000C03, 24'h0};
        int grants = 0;
        ready4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            empty4 = e_in[i];
            data4  = {24'hDEAD03, d_in[i], 24'hDEAD01, 24'hDEAD00};
            @(negedge clk);
            checks++;
            if ((rdreq4 & empty4) !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL skip_rdreq_on_empty%0d: got rdreq=%b empty=%b", i, rdreq4, empty4);
            end
            checks++;
            if (rdreq4 !== x_rd[i] || valid4 !== x_v[i]) begin
                errors++;
                $display("[TB] FAIL skip_step%0d: got rdreq=%b valid=%b expected %b %b",
                         i, rdreq4, valid4, x_rd[i], x_v[i]);
            end
            if (x_v[i]) begin
                checks++;
                if (dout4 !== x_d[i] || ch4 !== 2'd2) begin
                    errors++;
                    $display("[TB] FAIL skip_data%0d: got ch=%0d data=%h expected ch=2 data=%h",
                             i, ch4, dout4, x_d[i]);
                end
            end
            if (rdreq4 !== 4'b0000) grants++;
            tick();
        end
        checks++;
        if (grants !== 3) begin
            errors++;
            $display("[TB] FAIL skip_grant_count: got %0d expected 3", grants);
        end
    endtask

    task automatic test_gap;
        logic [1:0]  e_in [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
        logic [23:0] d_in [6] = '{24'h111111, 24'h222222, 24'h222222, 24'h222222, 24'h222222, 24'h222222};
        logic [1:0]  x_rd [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        logic        x_v  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [23:0] x_d  [6] = '{24'h0, 24'h111111, 24'h0, 24'h0, 24'h0, 24'h222222};
        int first_issue = -1;
        int second_issue = -1;
        readyg = 1'b1;
        for (int i = 0; i < 6; i++) begin
            emptyg = e_in[i];
            datag  = {24'h0, d_in[i]};
            @(negedge clk);
            checks++;
            if (rdreqg !== x_rd[i] || validg !== x_v[i]) begin
                errors++;
                $display("[TB] FAIL gap_step%0d: got rdreq=%b valid=%b expected %b %b",
                         i, rdreqg, validg, x_rd[i], x_v[i]);
            end
            if (x_v[i]) begin
                checks++;
                if (doutg !== x_d[i] || chg !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap_data%0d: got ch=%0d data=%h expected ch=0 data=%h",
                             i, chg, doutg, x_d[i]);
                end
            end
            if (rdreqg !== 2'b00) begin
                if (first_issue < 0) first_issue = i;
                else if (second_issue < 0) second_issue = i;
            end
            tick();
        end
        checks++;
        if (first_issue < 0 || second_issue - first_issue != 4) begin
            errors++;
            $display("[TB] FAIL gap_spacing: got issues at %0d and %0d expected spacing 4",
                     first_issue, second_issue);
        end
    endtask

    task automatic test_reset_mid;
        empty2 = 2'b10;
        data2  = {24'h0, 24'h0A0A0A};
        ready2 = 1'b0;
        @(negedge clk);
        checks++;
        if (rdreq2 !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rm_grant: got %b expected 01", rdreq2);
        end
        tick();
        empty2 = 2'b00;
        data2  = {24'h0B0B0B, 24'h0C0C0C};
        ready2 = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        checks++;
        if (rdreq2 !== 2'b00 || valid2 !== 1'b1 || dout2 !== 24'h0A0A0A) begin
            errors++;
            $display("[TB] FAIL rm_during_reset: got rdreq=%b valid=%b data=%h expected 00 1 0a0a0a",
                     rdreq2, valid2, dout2);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b0 || dout2 !== 24'h0 || rdreq2 !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rm_after_reset: got valid=%b data=%h rdreq=%b expected 0 0 01",
                     valid2, dout2, rdreq2);
        end
        tick();
        empty2 = 2'b11;
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b1 || ch2 !== 1'b0 || dout2 !== 24'h0C0C0C) begin
            errors++;
            $display("[TB] FAIL rm_first_sample: got valid=%b ch=%0d data=%h expected 1 0 0c0c0c",
                     valid2, ch2, dout2);
        end
        tick();
        tick();
    endtask

    task automatic test_late_empty;
        empty2 = 2'b10;
        data2  = {24'h0, 24'h0D0D0D};
        ready2 = 1'b0;
        @(negedge clk);
        checks++;
        if (rdreq2 !== 2'b01) begin
            errors++;
            $display("[TB] FAIL le_grant: got %b expected 01", rdreq2);
        end
        tick();
        empty2 = 2'b11;
        tick();
        empty2 = 2'b01;
        data2  = {24'h0E0E0E, 24'h0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rdreq2 !== 2'b00 || valid2 !== 1'b1 || dout2 !== 24'h0D0D0D) begin
                errors++;
                $display("[TB] FAIL le_hold%0d: got rdreq=%b valid=%b data=%h expected 00 1 0d0d0d",
                         i, rdreq2, valid2, dout2);
            end
            tick();
        end
        ready2 = 1'b1;
        @(negedge clk);
        checks++;
        if (rdreq2 !== 2'b10 || dout2 !== 24'h0D0D0D) begin
            errors++;
            $display("[TB] FAIL le_same_cycle_grant: got rdreq=%b data=%h expected 10 0d0d0d",
                     rdreq2, dout2);
        end
        tick();
        empty2 = 2'b11;
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b1 || ch2 !== 1'b1 || dout2 !== 24'h0E0E0E) begin
            errors++;
            $display("[TB] FAIL le_ch1_sample: got valid=%b ch=%0d data=%h expected 1 1 0e0e0e",
                     valid2, ch2, dout2);
        end
        tick();
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL le_drain: got valid=%b expected 0", valid2);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_skip_empty();
        test_gap();
        test_reset_mid();
        test_late_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Round-robin scheduler that shares one downstream EQ filter input between N_CH show-ahead sample FIFOs (e.g. L/R audio channels).
- Pops at most one sample per cycle from a granted FIFO.
- Registers the sample with a channel tag and presents it on a valid/ready output.
- Optionally enforces a minimum spacing between issues for a multi-cycle filter core.

Parameters:
- N_CH, 2, number of requesting FIFOs, 2..8.
- D_WIDTH, 24, sample width in bits.
- GAP, 0, number of idle cycles forced after each accepted output before the next issue. Range 0..255.
- CH_W, $clog2(N_CH) (minimum 1), width of the channel tag. Derived, not overridden.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_i  in  N_CH*D_WIDTH  show-ahead FIFO heads; channel k occupies bits [k*D_WIDTH +: D_WIDTH].
- empty_i  in  N_CH  per-FIFO empty flags.
- rdreq_o  out  N_CH  per-FIFO pop strobe, one-hot or zero.
- data_o  out  D_WIDTH  registered sample to the filter.
- ch_o  out  CH_W  channel index of data_o.
- valid_o  out  1  data_o/ch_o hold a sample.
- ready_i  in  1  filter accepts the sample when valid_o && ready_i.
- idle_o  out  1  high in IDLE with all empty_i high.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst_i high at a rising edge):
  - data_o=0, ch_o=0, valid_o=0.
  - Gap counter=0, state=IDLE, last-grant pointer=N_CH-1, so channel 0 has first priority.
  - rdreq_o is forced 0 in any cycle where rst_i is high. Reset mid-HOLD drops the held sample; the FIFO is not re-popped.
- FIFO contract (show-ahead):
  - data_i slice k is valid whenever empty_i[k]=0.
  - rdreq_o[k] high at an edge consumes that word.
  - rdreq_o[k] is never asserted while empty_i[k]=1.
- Issue condition, cycle t: slot_free = (state==IDLE) or (state==HOLD and ready_i and GAP==0).
- Arbitration:
  - If slot_free and any empty_i bit is low, grant g = first non-empty channel scanning last+1, last+2, ... modulo N_CH.
  - rdreq_o is combinational: rdreq_o[g]=1 in cycle t.
  - At the edge ending t: data_o<=data_i[g], ch_o<=g, valid_o<=1, last<=g.
- Latency: a non-empty head at cycle t with a free slot is at the output at t+1.
- Throughput: with GAP=0 and ready_i held high, one sample per cycle.
- State machine:
  - IDLE: valid_o=0.
    - Grant -> HOLD.
  - HOLD: valid_o=1; data_o and ch_o are stable until accepted.
    - ready_i=0 -> stay in HOLD.
    - ready_i=1, GAP=0 -> back-to-back grant possible in the same cycle; with a grant stay in HOLD, with no request go to IDLE (valid_o<=0).
    - ready_i=1, GAP>0 -> GAPW, counter<=GAP-1, valid_o<=0.
  - GAPW: valid_o=0, rdreq_o=0.
    - Counter decrements each cycle; at 0 -> IDLE. Issue is possible the cycle after the counter reaches 0.
    - GAP=1 gives exactly 1 empty output cycle between samples.
- Fairness:
  - Pointer wraps from N_CH-1 to 0.
  - With all channels continuously non-empty, grants cycle 0,1,...,N_CH-1,0,...
  - A channel that goes empty is skipped without consuming a slot.
- empty_i is sampled only in the issue cycle. Changes while in HOLD or GAPW have no effect.
- full_i and usedw are not used by this block.
- idle_o = (state==IDLE) && &empty_i. Combinational.

Test Plan:
- Reset, then with N_CH=2, GAP=0, ready_i=1, both FIFOs preloaded (ch0: 0x000001, 0x000002; ch1: 0xA00001, 0xA00002):
  - Outputs on consecutive cycles: (0,0x000001), (1,0xA00001), (0,0x000002), (1,0xA00002).
  - Then valid_o=0 and idle_o=1.
  - rdreq_o is one-hot on 4 consecutive cycles.
- Backpressure: ready_i=0 for 5 cycles while in HOLD with ch0 sample 0x123456.
  - data_o=0x123456 and valid_o=1 stable throughout.
  - rdreq_o=0 throughout.
  - When ready_i rises, the next sample appears 1 cycle later.
- Skip empty: N_CH=4 with only ch2 non-empty (3 words).
  - Three grants to ch2, ch_o=2 each.
  - rdreq_o never 1 on any bit where empty_i=1 (assertion check).
- GAP=3, ready_i=1, ch0 holding 2 words:
  - valid_o pattern is 1,0,0,0,1.
  - Second sample issues exactly 4 cycles after the first.
- Reset mid-operation: assert rst_i in a HOLD cycle.
  - Next cycle valid_o=0, rdreq_o=0 during reset.
  - After release the first grant goes to ch0 even if ch1 was next.
- Late empty change: empty_i[1] falls while ch0 is in HOLD with ready_i=0.
  - No rdreq_o[1] until ready_i=1.
  - Then ch1 is granted the same cycle as ch0's acceptance (GAP=0).
